hc165_reader: RTL and testbench
===============================

# hc165_reader

Serial reader for a chain of 74HC165 parallel-in/serial-out shift registers. It is the input-side counterpart of the board's 74HC595 display output chain. The block periodically, or on request, latches the switch and key inputs, shifts them in over a three-wire interface (LOAD_N, SCLK, QH), and presents the result as a parallel word with a one-cycle valid strobe and a change flag. It sits beside `hc595_driver` in top-level designs and feeds values such as `SW` to the rest of the logic.

## Interface
- `WIDTH`, 16: bits in the chain (8 per 74HC165); legal range 8..32.
- `CLK_DIV`, 25: clk cycles per SCLK/LOAD_N half-phase (default gives 1 MHz at 50 MHz); must be ≥4.
- `SCAN_PERIOD`, 50000: clk cycles between automatic scans (1 ms at 50 MHz).
- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  asynchronous reset, active low.
- `en`  in  1  enables the automatic periodic scan.
- `start`  in  1  single-cycle pulse requesting one scan.
- `QH`  in  1  serial data from the last 74HC165 in the chain; asynchronous to clk.
- `LOAD_N`  out  1  74HC165 SH/LD̅; low means parallel load.
- `SCLK`  out  1  74HC165 CLK; CLK INH is tied low on the board.
- `data`  out  WIDTH  last completed scan; bit WIDTH-1 is the first bit shifted out.
- `data_vld`  out  1  one-cycle pulse when `data` updates.
- `changed`  out  1  valid together with `data_vld`: new word differs from the previous word.
- `busy`  out  1  high while a scan is in progress.

## Operation
- **Reset values.** All outputs and internal state reset to: `LOAD_N`=1, `SCLK`=0, `data`=0, `data_vld`=0, `changed`=0, `busy`=0, FSM=IDLE, scan timer=0.
- **Input synchronizer.** `QH` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- **Scan timer.**
  - Counts 0..SCAN_PERIOD-1 while `en`=1 and wraps; the wrap cycle is the "tick".
  - The timer holds at 0 while `en`=0.
- **Scan start.** A tick or `start` while IDLE begins a scan.
  - A tick or `start` while busy is dropped, not queued.
  - A simultaneous tick and `start` produce exactly one scan.
- **FSM IDLE.**
  - `LOAD_N`=1, `SCLK`=0, `busy`=0.
  - Moves to LOAD on a scan start.
- **FSM LOAD.**
  - `LOAD_N`=0 for CLK_DIV cycles, then `LOAD_N`=1 for CLK_DIV cycles (settle time).
  - `busy`=1 from the first LOAD cycle onward.
- **FSM SHIFT.** Repeats WIDTH times, for bit index i = WIDTH-1 down to 0:
  - `SCLK`=0 for CLK_DIV cycles; the synchronized `QH` is sampled into shift register bit i on the last cycle of this low phase.
  - `SCLK`=1 for CLK_DIV cycles; the rising edge advances the chain.
  - The final rising edge shifts an unused bit. This is intentional and harmless.
- **FSM DONE.** Lasts one cycle.
  - `data` ← shift register.
  - `changed` ← (shift register != old `data`).
  - `data_vld`=1; `busy` drops to 0 in the next cycle (IDLE).
  - The first scan after reset compares against 0.
- **`en` deasserted mid-scan.** The current scan completes normally; no new automatic scans start.
- **`reset_n` asserted mid-scan.** The scan aborts immediately, all outputs return to reset values, and no `data_vld` is produced.

## Timing
- **Latency.** From the scan-start cycle to the `data_vld` cycle is 2·CLK_DIV + 2·CLK_DIV·WIDTH + 1 cycles. With the defaults this is 851 cycles.
- **SCLK.** Exactly WIDTH rising edges per scan, none outside SHIFT. Duty cycle is 50%, with period 2·CLK_DIV.
- **Setup/hold.** QH has settled ≥CLK_DIV cycles before its sampling point. CLK_DIV ≥4 covers the 2-cycle synchronizer delay.
- **Output stability.** `data` and `changed` hold their values until the next DONE.
- **Overlapping period.** If SCAN_PERIOD < scan latency, scans run back-to-back at the next tick after IDLE. Ticks that fall while busy are lost.

## Test plan
- **Basic read.** Two-chip 74HC165 model with parallel inputs 16'hA5C3, `start` pulse → 16 SCLK rises, `data`=16'hA5C3, `data_vld` exactly 851 cycles after `start`, `changed`=1.
- **Change detect.** Repeat the scan with the same inputs → `changed`=0. Change the inputs to 16'hA5C2 → `changed`=1 and `data`=16'hA5C2.
- **Periodic scan.** `SCAN_PERIOD`=2000, `en`=1 for 10000 cycles → `data_vld` pulses spaced exactly 2000 cycles apart. With `en`=0 → no LOAD_N activity.
- **Busy drop.** `start` issued 100 cycles into a scan → ignored; exactly one `data_vld` results.
- **Reset mid-scan.** `reset_n` low at cycle 400 of a scan → `LOAD_N`=1, `SCLK`=0, `data`=0 and `busy`=0 immediately. No `data_vld` until a new `start` is given.
- **Width/divider corner.** `WIDTH`=8, `CLK_DIV`=4, inputs 8'h81 → `data`=8'h81, latency 73 cycles, sampling correct at the minimum divider.

Source files
------------

// File: rtl/hc165_reader_if.sv
// hc165_reader_if: groups the scan control, the 74HC165 serial pins and the
// parallel result of hc165_reader into one bundle.
//   master : the reader (drives LOAD_N/SCLK and the result, receives en/start/QH)
//   slave  : the surrounding logic and board pins (drives en/start/QH)
interface hc165_reader_if #(
  parameter int WIDTH = 16
);
  logic             en;        // enable automatic periodic scans
  logic             start;     // single-cycle scan request
  logic             QH;        // serial data from the last 74HC165
  logic             LOAD_N;    // 74HC165 SH/LD_N, low = parallel load
  logic             SCLK;      // 74HC165 shift clock
  logic [WIDTH-1:0] data;      // last completed scan, MSB shifted out first
  logic             data_vld;  // one-cycle pulse when data updates
  logic             changed;   // with data_vld: new word differs from previous
  logic             busy;      // scan in progress

  modport master (
    input  en, start, QH,
    output LOAD_N, SCLK, data, data_vld, changed, busy
  );

  modport slave (
    output en, start, QH,
    input  LOAD_N, SCLK, data, data_vld, changed, busy
  );
endinterface

// File: rtl/hc165_reader.sv
// hc165_reader: periodic / on-demand reader of a 74HC165 PISO chain.
// Latency: scan start to data_vld = 2*CLK_DIV + 2*CLK_DIV*WIDTH + 1 clk cycles.
// Backpressure: none; start or timer ticks arriving while busy are dropped.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus (master) : en/start/QH in; LOAD_N/SCLK/data/data_vld/changed/busy out
module hc165_reader #(
  parameter int WIDTH       = 16,
  parameter int CLK_DIV     = 25,
  parameter int SCAN_PERIOD = 50000
) (
  input  logic            clk,
  input  logic            reset_n,
  hc165_reader_if.master  bus
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WIDTH);
  localparam int TW = $clog2(SCAN_PERIOD + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_FIRST  = BW'(WIDTH - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    div_cnt, div_cnt_nxt;
  logic             phase, phase_nxt;     // 0: first half-phase, 1: second
  logic [BW-1:0]    bit_idx, bit_idx_nxt;
  logic [WIDTH-1:0] shreg;
  logic [TW-1:0]    timer;
  logic             qh_meta, qh_sync;

  logic             load_n_q, sclk_q, vld_q, changed_q, busy_q;
  logic [WIDTH-1:0] data_q;

  logic             tick;
  logic             div_end;
  logic             sample;

  // QH is driven from off-chip, asynchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qh_meta <= 1'b0;
      qh_sync <= 1'b0;
    end else begin
      qh_meta <= bus.QH;
      qh_sync <= qh_meta;
    end
  end

  // Scan timer: wraps every SCAN_PERIOD cycles while enabled, parked at 0 otherwise.
  assign tick = bus.en && (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!bus.en || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  assign div_end = (div_cnt == DIV_LAST);
  // Last cycle of the SCLK-low half: QH has been stable for a full half-phase.
  assign sample  = (state == SHIFT) && !phase && div_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      phase   <= phase_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    phase_nxt   = phase;
    bit_idx_nxt = bit_idx;

    case (state)
      IDLE: begin
        // start and tick together still give a single scan.
        if (bus.start || tick) begin
          state_nxt   = LOAD;
          div_cnt_nxt = '0;
          phase_nxt   = 1'b0;
        end
      end

      // phase 0: LOAD_N low (parallel load), phase 1: LOAD_N high (settle)
      LOAD: begin
        if (div_end) begin
          div_cnt_nxt = '0;
          if (!phase) begin
            phase_nxt = 1'b1;
          end else begin
            state_nxt   = SHIFT;
            phase_nxt   = 1'b0;
            bit_idx_nxt = BIT_FIRST;
          end
        end else begin
          div_cnt_nxt = div_cnt + CW'(1);
        end
      end

      // phase 0: SCLK low (sample at end), phase 1: SCLK high (chain advances)
      SHIFT: begin
        if (div_end) begin
          div_cnt_nxt = '0;
          if (!phase) begin
            phase_nxt = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            if (bit_idx == '0) begin
              state_nxt = DONE;
            end else begin
              bit_idx_nxt = bit_idx - BW'(1);
            end
          end
        end else begin
          div_cnt_nxt = div_cnt + CW'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
        phase_nxt = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (sample) begin
      shreg[bit_idx] <= qh_sync;
    end
  end

  // Outputs are registered from the next-state decode so the board pins come
  // straight from flops and line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_n_q  <= 1'b1;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
      changed_q <= 1'b0;
      data_q    <= '0;
    end else begin
      load_n_q <= !((state_nxt == LOAD) && !phase_nxt);
      sclk_q   <= (state_nxt == SHIFT) && phase_nxt;
      busy_q   <= (state_nxt != IDLE);
      vld_q    <= (state_nxt == DONE);
      // Publish on entry to DONE so data/changed are valid with data_vld.
      if ((state == SHIFT) && (state_nxt == DONE)) begin
        data_q    <= shreg;
        changed_q <= (shreg != data_q);
      end
    end
  end

  assign bus.LOAD_N   = load_n_q;
  assign bus.SCLK     = sclk_q;
  assign bus.busy     = busy_q;
  assign bus.data_vld = vld_q;
  assign bus.changed  = changed_q;
  assign bus.data     = data_q;

endmodule

// File: tb/tb_hc165_reader.sv
// tb_hc165_reader: directed bench for hc165_reader with behavioural 74HC165
// chains; expected words are queued when a scan is requested and compared
// when data_vld appears.
module tb_hc165_reader;

  localparam int WA = 16;
  localparam int DA = 25;
  localparam int PA = 2000;
  localparam int WB = 8;
  localparam int DB = 4;
  localparam int LAT_A = 2*DA + 2*DA*WA + 1;   // 851
  localparam int LAT_B = 2*DB + 2*DB*WB + 1;   // 73

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  hc165_reader_if #(.WIDTH(WA)) bus_a ();
  hc165_reader_if #(.WIDTH(WB)) bus_b ();

  hc165_reader #(.WIDTH(WA), .CLK_DIV(DA), .SCAN_PERIOD(PA)) dut_a (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus_a.master)
  );

  hc165_reader #(.WIDTH(WB), .CLK_DIV(DB), .SCAN_PERIOD(50000)) dut_b (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus_b.master)
  );

  // 74HC165 chains: parallel load while SH/LD_N low, shift on SCLK rise.
  logic [WA-1:0] par_a, chain_a;
  logic [WB-1:0] par_b, chain_b;

  always @(posedge bus_a.SCLK or negedge bus_a.LOAD_N)
    if (!bus_a.LOAD_N) chain_a <= par_a;
    else               chain_a <= {chain_a[WA-2:0], 1'b0};

  always @(posedge bus_b.SCLK or negedge bus_b.LOAD_N)
    if (!bus_b.LOAD_N) chain_b <= par_b;
    else               chain_b <= {chain_b[WB-2:0], 1'b0};

  assign bus_a.QH = chain_a[WA-1];
  assign bus_b.QH = chain_b[WB-1];

  // Activity monitors (each written by one process only).
  int cyc = 0;
  int vld_cnt_a = 0;
  int loadn_falls_a = 0;
  int sclk_rises_a = 0;
  int sclk_rises_b = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus_a.data_vld === 1'b1) vld_cnt_a <= vld_cnt_a + 1;
  always @(negedge bus_a.LOAD_N) loadn_falls_a <= loadn_falls_a + 1;
  always @(posedge bus_a.SCLK) sclk_rises_a <= sclk_rises_a + 1;
  always @(posedge bus_b.SCLK) sclk_rises_b <= sclk_rises_b + 1;

  typedef struct packed {
    logic [WA-1:0] d;
    logic          ch;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_a();
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
  endtask

  // Called at the negedge of the first scan cycle; n counts scan cycles.
  task automatic wait_vld_a(input string tag, input int budget, output int n, output int stamp);
    exp_t e;
    n = 1;
    while (bus_a.data_vld !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    stamp = cyc;
    check({tag, "_vld"}, 32'(bus_a.data_vld), 32'd1);
    check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, 32'(bus_a.data), 32'(e.d));
      check({tag, "_changed"}, 32'(bus_a.changed), 32'(e.ch));
    end
    @(negedge clk);
    check({tag, "_vld_pulse"}, 32'(bus_a.data_vld), 32'd0);
  endtask

  int n, ts, t_prev, r0, v0, l0;

  initial begin
    bus_a.en = 1'b0; bus_a.start = 1'b0;
    bus_b.en = 1'b0; bus_b.start = 1'b0;
    par_a = 16'hA5C3;
    par_b = 8'h81;

    // Reset values
    repeat (4) @(negedge clk);
    check("rst_load_n",   32'(bus_a.LOAD_N),   32'd1);
    check("rst_sclk",     32'(bus_a.SCLK),     32'd0);
    check("rst_data",     32'(bus_a.data),     32'd0);
    check("rst_data_vld", 32'(bus_a.data_vld), 32'd0);
    check("rst_changed",  32'(bus_a.changed),  32'd0);
    check("rst_busy",     32'(bus_a.busy),     32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic read
    sb.push_back({16'hA5C3, 1'b1});
    r0 = sclk_rises_a;
    start_a();
    check("basic_busy", 32'(bus_a.busy), 32'd1);
    check("basic_load_n_low", 32'(bus_a.LOAD_N), 32'd0);
    wait_vld_a("basic", 3000, n, ts);
    check("basic_latency", 32'(n), 32'(LAT_A));
    check("basic_sclk_rises", 32'(sclk_rises_a - r0), 32'(WA));
    check("basic_busy_idle", 32'(bus_a.busy), 32'd0);

    // Same inputs: no change; then flip bit 0
    sb.push_back({16'hA5C3, 1'b0});
    start_a();
    wait_vld_a("same", 3000, n, ts);
    par_a = 16'hA5C2;
    sb.push_back({16'hA5C2, 1'b1});
    start_a();
    wait_vld_a("lsb_change", 3000, n, ts);
    check("lsb_change_latency", 32'(n), 32'(LAT_A));
    repeat (20) @(negedge clk);
    check("data_hold", 32'(bus_a.data), 32'h0000A5C2);

    // start while busy is dropped
    par_a = 16'h3C5A;
    sb.push_back({16'h3C5A, 1'b1});
    v0 = vld_cnt_a;
    start_a();
    repeat (99) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_vld_a("busy_drop", 3000, n, ts);
    repeat (1000) @(negedge clk);
    check("busy_drop_one_vld", 32'(vld_cnt_a - v0), 32'd1);

    // Periodic scans
    par_a = 16'h0F0F;
    @(negedge clk);
    bus_a.en = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({16'h0F0F, (i == 0)});
      wait_vld_a("periodic", 4000, n, ts);
      if (i > 0) check("periodic_spacing", 32'(ts - t_prev), 32'(PA));
      t_prev = ts;
    end
    bus_a.en = 1'b0;
    l0 = loadn_falls_a;
    v0 = vld_cnt_a;
    repeat (5000) @(negedge clk);
    check("en_off_load_n_idle", 32'(loadn_falls_a - l0), 32'd0);
    check("en_off_no_vld", 32'(vld_cnt_a - v0), 32'd0);

    // Reset mid-scan
    v0 = vld_cnt_a;
    start_a();
    repeat (399) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_load_n",   32'(bus_a.LOAD_N),   32'd1);
    check("midrst_sclk",     32'(bus_a.SCLK),     32'd0);
    check("midrst_data",     32'(bus_a.data),     32'd0);
    check("midrst_busy",     32'(bus_a.busy),     32'd0);
    check("midrst_data_vld", 32'(bus_a.data_vld), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    check("midrst_no_vld", 32'(vld_cnt_a - v0), 32'd0);
    sb.push_back({16'h0F0F, 1'b1});
    start_a();
    wait_vld_a("after_rst", 3000, n, ts);
    check("after_rst_latency", 32'(n), 32'(LAT_A));

    // Minimum divider, 8-bit chain
    r0 = sclk_rises_b;
    @(negedge clk); bus_b.start = 1'b1;
    @(negedge clk); bus_b.start = 1'b0;
    n = 1;
    while (bus_b.data_vld !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("w8_vld", 32'(bus_b.data_vld), 32'd1);
    check("w8_latency", 32'(n), 32'(LAT_B));
    check("w8_data", 32'(bus_b.data), 32'h00000081);
    check("w8_changed", 32'(bus_b.changed), 32'd1);
    check("w8_sclk_rises", 32'(sclk_rises_b - r0), 32'(WB));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
